instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Encodes operation requests (ALU op, register fields, NOP) into 32-bit instruction words and streams them into instruction memory at consecutive addresses.
- Produces the opcodes that the control unit decodes: ADD..SRL are 6'b000000..6'b000111, and NOP/no-write is 6'b111111.
- Sits between the program loader or test sequencer and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width; DEPTH = 2**ADDR_WIDTH.
- REG_ADDR_WIDTH, 5, register index width; fixed at 5 for the 32-bit format.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a program load at base_addr; ignored unless in IDLE.
- base_addr  input  ADDR_WIDTH  first write address, sampled on start.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder accepts a request this cycle.
- in_alu_op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SLL, 7 SRL.
- in_nop  input  1  encode NOP; overrides in_alu_op.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_last  input  1  marks the final request of the program.
- mem_wr_en  output  1  memory write strobe.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  memory accepts the write this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at the end of a load.
- count  output  ADDR_WIDTH+1  words written since start.
- overflow  output  1  sticky; the load exceeded the memory end.

Behaviour:
- Reset (async): state=IDLE; in_ready, mem_wr_en, done, busy, overflow = 0; mem_addr, mem_wdata, count = 0.
- Encoding:
  - [31:26] opcode = in_nop ? 6'b111111 : {3'b000, in_alu_op}.
  - [25:21] rd, [20:16] rs1, [15:11] rs2, [10:0] = 0.
  - NOP still carries its register fields.
- IDLE:
  - in_ready=0.
  - On start: mem_addr<=base_addr, count<=0, overflow<=0, go ACCEPT.
- ACCEPT:
  - in_ready=1 (registered; asserted the cycle after entry).
  - When in_valid & in_ready: mem_wdata<=encoded word, last_q<=in_last, go WRITE.
- WRITE:
  - in_ready=0; mem_wr_en=1 with mem_addr and mem_wdata held stable until mem_ready.
  - When mem_ready: count<=count+1, then:
    - last_q -> DONE, mem_addr unchanged.
    - else if mem_addr==DEPTH-1 -> overflow<=1, go DONE (no wrap to 0).
    - else mem_addr<=mem_addr+1, go ACCEPT.
- DONE: done=1 for exactly one cycle, busy=1, then go IDLE.
- Timing and throughput:
  - Latency: request accepted at edge N -> mem_wr_en high after edge N (cycle N+1).
  - Peak throughput is one word per 2 cycles when mem_ready is tied high.
- Handshakes:
  - in_valid with in_ready low is ignored; the requester must hold it.
  - mem_ready while mem_wr_en is low is ignored.
- Boundary cases:
  - start while busy: ignored.
  - Overflow: the word at DEPTH-1 is written, then the load ends.
  - base_addr=DEPTH-1 with a single in_last request: no overflow.
  - count saturates naturally at DEPTH via the extra width bit.
- Reset mid-operation: any pending write is dropped, mem_wr_en falls immediately (async), and no done pulse is produced.

Test Plan:
- start, base_addr=0x10; ADD rd=1, rs1=2, rs2=3, last=1; mem_ready=1 -> one write, addr 0x10, data 0x00221800; done pulses one cycle later; count=1.
- SUB r4,r5,r6 then NOP (rd=rs1=rs2=0, last), base 0 -> writes 0x04853000 at 0x00 and 0xFC000000 at 0x01; count=2; in_ready low during each WRITE.
- SRL r31,r31,r31 with mem_ready low for 3 cycles -> mem_wr_en, mem_addr, and mem_wdata=0x1FFFF800 stable for 4 cycles; exactly one write.
- base_addr=0xFE, three non-last requests -> writes at 0xFE and 0xFF; overflow=1, done pulses, count=2; third request never accepted.
- Assert reset while in WRITE -> mem_wr_en=0 in the same cycle, all outputs at reset values, no done; new start afterwards works normally.
- Pulse start while busy, and send in_valid while IDLE -> no effect on mem_addr or count; no write.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs operation requests into 32-bit instruction
// words and streams them into instruction memory at consecutive addresses,
// starting from a base address latched on start.
module instr_encoder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_alu_op,
  input  logic                      in_nop,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic                      in_last,
  output logic                      mem_wr_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH:0]       count,
  output logic                      overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [5:0]            OP_NOP   = 6'b111111;

  // Instruction format: opcode | rd | rs1 | rs2 | 11 zero bits.
  // A NOP keeps its register fields so the word is still traceable.
  function automatic logic [31:0] encode_word(
    input logic                      nop,
    input logic [2:0]                op,
    input logic [REG_ADDR_WIDTH-1:0] rd,
    input logic [REG_ADDR_WIDTH-1:0] rs1,
    input logic [REG_ADDR_WIDTH-1:0] rs2
  );
    logic [5:0] opcode;
    opcode = nop ? OP_NOP : {3'b000, op};
    return {opcode, rd, rs1, rs2, 11'b0};
  endfunction

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  last_q, last_d;

  // Next-state and next-output logic; flag outputs are derived from the next
  // state so they are registered and line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    last_d      = last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_addr_d = base_addr;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          mem_wdata_d = encode_word(in_nop, in_alu_op, in_rd, in_rs1, in_rs2);
          last_d      = in_last;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          count_d = count_q + CNT_ONE;
          if (last_q) begin
            state_d = S_DONE;
          end else if (mem_addr_q == ADDR_MAX) begin
            // Top of memory reached with more words pending: stop, never wrap.
            overflow_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_ONE;
            state_d    = S_ACCEPT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_ACCEPT);
    mem_wr_en_d = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers; reset is asynchronous so a pending write
  // strobe drops immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      last_q      <= last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
